result_sample_buffer: RTL

Parametrised successor to the single-byte LED sample register in the dual-datapath top level. Each `hz1_clk` tick it captures the write-back results of up to `CHANNELS` datapaths into a circular history buffer. It drives one selected byte to the 7-segment mux. Supported modes are live view, record-until-full, frozen hold, and step-through replay of the captured history.

---
 rtl/result_sample_buffer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/result_sample_buffer.sv
// Circular history of per-channel write-back results with live, record, hold
// and step-through replay views, driving one selected byte to the display mux.
module result_sample_buffer #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  localparam int CSW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int BSW     = ((WIDTH / 8) > 1) ? $clog2(WIDTH / 8) : 1,
  localparam int PW      = $clog2(DEPTH),
  localparam int CNW     = $clog2(DEPTH + 1)
) (
  input  logic                      hz1_clk,
  input  logic                      n_rst,
  input  logic [CHANNELS*WIDTH-1:0] ch_data,
  input  logic [CHANNELS-1:0]       ch_valid,
  input  logic [1:0]                mode,
  input  logic [CSW-1:0]            ch_sel,
  input  logic [BSW-1:0]            byte_sel,
  input  logic                      step,
  input  logic                      clear,
  output logic [7:0]                disp_byte,
  output logic [CNW-1:0]            count,
  output logic                      full,
  output logic                      overflow,
  output logic [PW-1:0]             rd_ptr
);

  localparam int LANES = WIDTH / 8;
  localparam logic [CNW-1:0] FULL_CNT = CNW'(DEPTH);

  typedef enum logic [1:0] {
    ST_LIVE   = 2'b00,
    ST_RECORD = 2'b01,
    ST_REPLAY = 2'b10,
    ST_HOLD   = 2'b11
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_capture;
  logic                      w_replay_entry;
  logic                      w_step_ok;
  logic                      w_we;
  logic                      w_drop;
  logic                      w_full;
  logic [PW-1:0]             r_wr_ptr;
  logic [PW-1:0]             r_rd_ptr;
  logic [PW-1:0]             w_oldest;
  logic [PW-1:0]             w_rd_inc;
  logic [CNW-1:0]            r_count;
  logic                      r_overflow;
  logic [7:0]                r_disp;
  logic [7:0]                w_live_byte;
  logic [7:0]                w_rep_byte;
  int                        w_ch;
  int                        w_bl;
  logic [CHANNELS*WIDTH-1:0] r_mem_data [DEPTH];
  logic [CHANNELS-1:0]       r_mem_vld  [DEPTH];

  function automatic logic [7:0] pick_byte(input logic [CHANNELS*WIDTH-1:0] d,
                                           input int c, input int b);
    return d[c*WIDTH + b*8 +: 8];
  endfunction

  always_ff @(posedge hz1_clk or negedge n_rst) begin
    if (!n_rst) r_state <= ST_LIVE;
    else        r_state <= w_state_nxt;
  end

  // The sampled mode governs the edge that samples it, so decode from the next state.
  always_comb begin
    w_state_nxt    = state_t'(mode);
    w_capture      = 1'b0;
    w_replay_entry = 1'b0;
    w_step_ok      = 1'b0;
    case (w_state_nxt)
      ST_LIVE, ST_RECORD: w_capture = |ch_valid;
      ST_REPLAY: begin
        w_replay_entry = (r_state != ST_REPLAY);
        w_step_ok      = step && !w_replay_entry && (r_count != '0);
      end
      default: ;
    endcase
  end

  assign w_full   = (r_count == FULL_CNT);
  assign w_we     = w_capture && !clear && ((w_state_nxt == ST_LIVE) || !w_full);
  assign w_drop   = w_capture && !clear && (w_state_nxt == ST_RECORD) && w_full;
  assign w_oldest = r_wr_ptr - PW'(r_count);
  assign w_rd_inc = r_rd_ptr + 1'b1;

  always_ff @(posedge hz1_clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_we) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (!w_full) r_count <= r_count + 1'b1;
      end
      if (w_drop) r_overflow <= 1'b1;
      // Stepping past the newest entry (the one just behind wr_ptr) returns to the oldest.
      if (w_replay_entry)  r_rd_ptr <= w_oldest;
      else if (w_step_ok)  r_rd_ptr <= (w_rd_inc == r_wr_ptr) ? w_oldest : w_rd_inc;
    end
  end

  always_ff @(posedge hz1_clk) begin
    if (w_we) begin
      r_mem_data[r_wr_ptr] <= ch_data;
      r_mem_vld[r_wr_ptr]  <= ch_valid;
    end
  end

  always_comb begin
    w_ch        = (int'(ch_sel) < CHANNELS) ? int'(ch_sel) : 0;
    w_bl        = (int'(byte_sel) < LANES) ? int'(byte_sel) : 0;
    w_live_byte = pick_byte(ch_data, w_ch, w_bl);
    w_rep_byte  = 8'h00;
    if ((r_count != '0) && r_mem_vld[r_rd_ptr][w_ch])
      w_rep_byte = pick_byte(r_mem_data[r_rd_ptr], w_ch, w_bl);
  end

  always_ff @(posedge hz1_clk or negedge n_rst) begin
    if (!n_rst) begin
      r_disp <= 8'h00;
    end else begin
      case (w_state_nxt)
        ST_LIVE, ST_RECORD: r_disp <= w_live_byte;
        ST_REPLAY:          r_disp <= w_rep_byte;
        default:            r_disp <= r_disp;
      endcase
    end
  end

  assign disp_byte = r_disp;
  assign count     = r_count;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign rd_ptr    = r_rd_ptr;

endmodule
